// File: rtl/oam_dma_if.sv
// CPU register port, source read port and OAM write port of the OAM DMA engine.
interface oam_dma_if;
    logic        reg_write_en;
    logic        reg_read_en;
    logic [15:0] reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic        src_read_req;
    logic [15:0] src_addr;
    logic [7:0]  src_rdata;
    logic        oam_write_en;
    logic [7:0]  oam_addr;
    logic [7:0]  oam_wdata;
    logic        dma_active;
    logic        cpu_block;

    modport master (
        output reg_write_en, reg_read_en, reg_addr, reg_wdata, src_rdata,
        input  reg_rdata, src_read_req, src_addr, oam_write_en, oam_addr,
               oam_wdata, dma_active, cpu_block
    );

    modport slave (
        input  reg_write_en, reg_read_en, reg_addr, reg_wdata, src_rdata,
        output reg_rdata, src_read_req, src_addr, oam_write_en, oam_addr,
               oam_wdata, dma_active, cpu_block
    );
endinterface

// File: rtl/oam_dma_controller.sv
// OAM DMA engine: a write to FF46 copies 160 bytes from {FF46, 00} into OAM.
// Optional macro OAM_DMA_CPU_BLOCK_EN drives cpu_block for everything outside HRAM.
module oam_dma_controller #(
    parameter int unsigned CYCLES_PER_BYTE = 4,
    parameter int unsigned STARTUP_CYCLES  = 4
) (
    input  logic      clk,
    input  logic      reset,
    oam_dma_if.slave  bus
);
    localparam int unsigned PW = $clog2(CYCLES_PER_BYTE);
    localparam int unsigned CW = $clog2(STARTUP_CYCLES + 1);
    localparam logic [PW-1:0] PH_LATCH = PW'(1);
    localparam logic [PW-1:0] PH_WRITE = PW'(2);
    localparam logic [PW-1:0] PH_LAST  = PW'(CYCLES_PER_BYTE - 1);
    localparam logic [CW-1:0] CNT_INIT = CW'(STARTUP_CYCLES - 1);
    localparam logic [7:0]    LAST_INDEX = 8'd159;
    localparam logic [15:0]   DMA_REG    = 16'hFF46;

    typedef enum logic [1:0] {
        S_IDLE,
        S_STARTUP,
        S_ACTIVE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [7:0]    index_q, index_d;
    logic [PW-1:0] phase_q, phase_d;
    logic [7:0]    data_q, data_d;
    logic [7:0]    src_hi_q, src_hi_d;
    logic          run_q, run_d;
    logic          restart_q, restart_d;

    logic          src_read_req_q, src_read_req_d;
    logic [15:0]   src_addr_q, src_addr_d;
    logic          oam_write_en_q, oam_write_en_d;
    logic [7:0]    oam_addr_q, oam_addr_d;
    logic [7:0]    oam_wdata_q, oam_wdata_d;
    logic          dma_active_q, dma_active_d;
    logic          cpu_block_q, cpu_block_d;

    logic          reg_wr;
    logic          step;
    logic          last_ph;
    logic          done;
    logic [PW-1:0] eng_phase;
    logic [7:0]    eng_index;
    logic          xfer_d;
    logic          rd_d;
    logic          wr_d;

    // Source pages E0-FF fold down by 0x20 so the DMA never reads OAM or I/O.
    function automatic logic [7:0] eff_hi(input logic [7:0] hi);
        return (hi >= 8'hE0) ? hi - 8'h20 : hi;
    endfunction

    assign reg_wr = bus.reg_write_en && (bus.reg_addr == DMA_REG);

    assign bus.reg_rdata = (bus.reg_read_en && (bus.reg_addr == DMA_REG)) ? src_hi_q : 8'hFF;

    // Byte engine; also runs during a restart window while the old copy is unfinished.
    always_comb begin
        step      = (state_q == S_ACTIVE) || ((state_q == S_STARTUP) && run_q);
        last_ph   = (phase_q == PH_LAST);
        done      = step && last_ph && (index_q == LAST_INDEX);
        eng_phase = phase_q;
        eng_index = index_q;
        if (step) begin
            if (last_ph) begin
                eng_phase = '0;
                eng_index = done ? 8'd0 : index_q + 8'd1;
            end else begin
                eng_phase = phase_q + PW'(1);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        index_d   = index_q;
        phase_d   = phase_q;
        src_hi_d  = src_hi_q;
        run_d     = run_q;
        restart_d = restart_q;
        data_d    = (step && (phase_q == PH_LATCH)) ? bus.src_rdata : data_q;

        if (reg_wr) begin
            src_hi_d  = bus.reg_wdata;
            state_d   = S_STARTUP;
            cnt_d     = CNT_INIT;
            run_d     = step && !done;
            restart_d = (state_q == S_ACTIVE) || ((state_q == S_STARTUP) && restart_q);
            index_d   = eng_index;
            phase_d   = eng_phase;
        end else begin
            case (state_q)
                S_STARTUP: begin
                    if (cnt_q == '0) begin
                        state_d   = S_ACTIVE;
                        index_d   = '0;
                        phase_d   = '0;
                        run_d     = 1'b0;
                        restart_d = 1'b0;
                    end else begin
                        cnt_d   = cnt_q - CW'(1);
                        index_d = eng_index;
                        phase_d = eng_phase;
                        if (done) begin
                            run_d = 1'b0;
                        end
                    end
                end
                S_ACTIVE: begin
                    index_d = eng_index;
                    phase_d = eng_phase;
                    if (done) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                end
            endcase
        end

        // Outputs are registered, so they are derived from next-state values.
        xfer_d         = (state_d == S_ACTIVE) || ((state_d == S_STARTUP) && run_d);
        rd_d           = xfer_d && (phase_d == '0);
        wr_d           = xfer_d && (phase_d == PH_WRITE);
        src_read_req_d = rd_d;
        src_addr_d     = rd_d ? {eff_hi(src_hi_d), index_d} : src_addr_q;
        oam_write_en_d = wr_d;
        oam_addr_d     = wr_d ? index_d : oam_addr_q;
        oam_wdata_d    = wr_d ? data_d : oam_wdata_q;
        dma_active_d   = (state_d == S_ACTIVE) || ((state_d == S_STARTUP) && restart_d);
`ifdef OAM_DMA_CPU_BLOCK_EN
        cpu_block_d    = dma_active_d && !(bus.reg_addr inside {[16'hFF80:16'hFFFE]});
`else
        cpu_block_d    = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= S_IDLE;
            cnt_q          <= '0;
            index_q        <= '0;
            phase_q        <= '0;
            data_q         <= '0;
            src_hi_q       <= 8'hFF;
            run_q          <= 1'b0;
            restart_q      <= 1'b0;
            src_read_req_q <= 1'b0;
            src_addr_q     <= '0;
            oam_write_en_q <= 1'b0;
            oam_addr_q     <= '0;
            oam_wdata_q    <= '0;
            dma_active_q   <= 1'b0;
            cpu_block_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            index_q        <= index_d;
            phase_q        <= phase_d;
            data_q         <= data_d;
            src_hi_q       <= src_hi_d;
            run_q          <= run_d;
            restart_q      <= restart_d;
            src_read_req_q <= src_read_req_d;
            src_addr_q     <= src_addr_d;
            oam_write_en_q <= oam_write_en_d;
            oam_addr_q     <= oam_addr_d;
            oam_wdata_q    <= oam_wdata_d;
            dma_active_q   <= dma_active_d;
            cpu_block_q    <= cpu_block_d;
        end
    end

    assign bus.src_read_req = src_read_req_q;
    assign bus.src_addr     = src_addr_q;
    assign bus.oam_write_en = oam_write_en_q;
    assign bus.oam_addr     = oam_addr_q;
    assign bus.oam_wdata    = oam_wdata_q;
    assign bus.dma_active   = dma_active_q;
    assign bus.cpu_block    = cpu_block_q;

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed bench for oam_dma_controller with a read/write scoreboard.
module tb_oam_dma_controller;
`ifdef OAM_DMA_CPU_BLOCK_EN
    localparam logic CPU_BLK_EXP = 1'b1;
`else
    localparam logic CPU_BLK_EXP = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    oam_dma_if bus ();

    oam_dma_controller dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int          n_chk = 0;
    int          n_pass = 0;
    int          cyc = 0;
    int          n_dma = 0;
    int          first_rd = -1;
    logic [15:0] rd_q[$];
    logic [15:0] wr_q[$];

    function automatic logic [7:0] mem_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h9A;
    endfunction

    function automatic logic [7:0] eff_hi(input logic [7:0] hi);
        return (hi >= 8'hE0) ? hi - 8'h20 : hi;
    endfunction

    // Source memory: data appears the cycle after the request, zero otherwise.
    always @(posedge clk)
        bus.src_rdata <= bus.src_read_req ? mem_byte(bus.src_addr) : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(negedge clk);
        cyc++;
        if (bus.dma_active === 1'b1) n_dma++;
        if (bus.src_read_req === 1'b1) begin
            if (first_rd < 0) first_rd = cyc;
            if (rd_q.size() == 0) chk("src_read_req with nothing expected", 32'(bus.src_read_req), 32'd0);
            else chk("src_addr", 32'(bus.src_addr), 32'(rd_q.pop_front()));
        end
        if (bus.oam_write_en === 1'b1) begin
            if (wr_q.size() == 0) chk("oam_write_en with nothing expected", 32'(bus.oam_write_en), 32'd0);
            else chk("oam addr/data", 32'({bus.oam_addr, bus.oam_wdata}), 32'(wr_q.pop_front()));
        end
    endtask

    task automatic push_xfer(input logic [7:0] hi, input int first, input int last);
        logic [15:0] a;
        for (int i = first; i <= last; i++) begin
            a = {eff_hi(hi), 8'(i)};
            rd_q.push_back(a);
            wr_q.push_back({8'(i), mem_byte(a)});
        end
    endtask

    task automatic cpu_write(input logic [15:0] addr, input logic [7:0] data);
        bus.reg_write_en = 1'b1;
        bus.reg_addr     = addr;
        bus.reg_wdata    = data;
        tick();
        bus.reg_write_en = 1'b0;
        bus.reg_addr     = 16'h0000;
    endtask

    task automatic read_ff46(input string tag, input logic [7:0] exp);
        bus.reg_read_en = 1'b1;
        bus.reg_addr    = 16'hFF46;
        #1;
        chk(tag, 32'(bus.reg_rdata), 32'(exp));
        bus.reg_read_en = 1'b0;
        bus.reg_addr    = 16'h0000;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " src_read_req"}, 32'(bus.src_read_req), 32'd0);
        chk({tag, " oam_write_en"}, 32'(bus.oam_write_en), 32'd0);
        chk({tag, " dma_active"}, 32'(bus.dma_active), 32'd0);
        chk({tag, " cpu_block"}, 32'(bus.cpu_block), 32'd0);
        chk({tag, " src_addr"}, 32'(bus.src_addr), 32'd0);
        chk({tag, " oam_addr"}, 32'(bus.oam_addr), 32'd0);
        chk({tag, " oam_wdata"}, 32'(bus.oam_wdata), 32'd0);
    endtask

    task automatic drain(input string tag, input int budget);
        int n = 0;
        while ((wr_q.size() != 0 || rd_q.size() != 0 || bus.dma_active !== 1'b0) && n < budget) begin
            tick();
            n++;
        end
        chk({tag, " pending oam writes"}, 32'(wr_q.size()), 32'd0);
        chk({tag, " pending src reads"}, 32'(rd_q.size()), 32'd0);
    endtask

    initial begin
        int w;
        reset            = 1'b0;
        bus.reg_write_en = 1'b0;
        bus.reg_read_en  = 1'b0;
        bus.reg_addr     = 16'h0000;
        bus.reg_wdata    = 8'h00;
        repeat (2) tick();
        chk_reset_outputs("reset");
        read_ff46("FF46 in reset", 8'hFF);
        reset = 1'b1;
        tick();

        // Neighbouring registers must not start a transfer.
        n_dma = 0;
        first_rd = -1;
        cpu_write(16'hFF45, 8'hC0);
        cpu_write(16'hFF47, 8'hC0);
        repeat (20) tick();
        chk("decode dma_active cycles", 32'(n_dma), 32'd0);
        chk("decode no src read", 32'(first_rd), 32'hFFFF_FFFF);
        read_ff46("FF46 before any write", 8'hFF);

        // Full copy from C000.
        n_dma = 0;
        first_rd = -1;
        w = cyc;
        push_xfer(8'hC0, 0, 159);
        cpu_write(16'hFF46, 8'hC0);
        while (cyc < w + 3) tick();
        chk("startup dma_active", 32'(bus.dma_active), 32'd0);
        while (cyc < w + 20) tick();
        bus.reg_addr = 16'hFF90;
        repeat (2) tick();
        chk("cpu_block at HRAM", 32'(bus.cpu_block), 32'd0);
        bus.reg_addr = 16'hC000;
        repeat (2) tick();
        chk("cpu_block at C000", 32'(bus.cpu_block), 32'(CPU_BLK_EXP));
        bus.reg_addr = 16'h0000;
        drain("full copy", 1000);
        chk("first src_read_req cycle", 32'(first_rd), 32'(w + 5));
        chk("full copy dma_active cycles", 32'(n_dma), 32'd640);
        read_ff46("FF46 after C0", 8'hC0);

        // Mirrored source, then a rewrite on the final OAM write cycle.
        n_dma = 0;
        w = cyc;
        push_xfer(8'hFE, 0, 159);
        cpu_write(16'hFF46, 8'hFE);
        read_ff46("FF46 after FE", 8'hFE);
        while (cyc < w + 643) tick();
        push_xfer(8'hC0, 0, 159);
        cpu_write(16'hFF46, 8'hC0);
        drain("mirror+final-write restart", 2000);
        chk("mirror+restart dma_active cycles", 32'(n_dma), 32'd1283);

        // Restart at byte 50: byte 51 reads the new page, then restart from index 0.
        n_dma = 0;
        w = cyc;
        push_xfer(8'hC0, 0, 50);
        cpu_write(16'hFF46, 8'hC0);
        while (cyc < w + 207) tick();
        push_xfer(8'hD0, 51, 51);
        push_xfer(8'hD0, 0, 159);
        cpu_write(16'hFF46, 8'hD0);
        drain("restart", 1500);
        chk("restart dma_active cycles", 32'(n_dma), 32'd847);

        // Reset at byte 80 phase 1.
        w = cyc;
        push_xfer(8'hC0, 0, 159);
        cpu_write(16'hFF46, 8'hC0);
        while (cyc < w + 326) tick();
        reset = 1'b0;
        #1;
        chk_reset_outputs("mid-transfer reset");
        chk("oam writes outstanding at reset", 32'(wr_q.size()), 32'd80);
        chk("src reads outstanding at reset", 32'(rd_q.size()), 32'd79);
        rd_q.delete();
        wr_q.delete();
        read_ff46("FF46 during reset", 8'hFF);
        repeat (2) tick();
        reset = 1'b1;
        n_dma = 0;
        repeat (700) tick();
        chk("dma_active after reset", 32'(n_dma), 32'd0);
        read_ff46("FF46 after reset", 8'hFF);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
